// File: rtl/video_timing_seq.sv
// Raster timing sequencer: walks a pixel/line grid and emits registered sync, blank and pulse outputs.
// Stopping is deferred to the end of the current frame. Resuming before then keeps the counters running.
module video_timing_seq #(
  parameter int H_ACTIVE = 8,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 3,
  parameter int H_BP     = 3,
  parameter int V_ACTIVE = 4,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 1,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          pix_en,
  output logic          busy,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          hsync,
  output logic          vsync,
  output logic          csync,
  output logic          cblank,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYN_LO = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYN_HI = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYN_LO = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYN_HI = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          busy_q, hsync_q, vsync_q, csync_q, cblank_q, active_q;
  logic          hsync_d, vsync_d, csync_d, cblank_d, active_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [7:0]    frame_cnt_q;
  logic          frame_inc;
  logic          advance, h_wrap, v_wrap;

  function automatic logic in_window(input logic [CW-1:0] c,
                                     input logic [CW-1:0] lo,
                                     input logic [CW-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_inc     = 1'b0;
    advance       = pix_en && (state_q != IDLE);
    h_wrap        = (hcnt_q == H_LAST);
    v_wrap        = (vcnt_q == V_LAST);

    if (advance) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + CW'(1);
      if (h_wrap) begin
        vcnt_d = v_wrap ? '0 : vcnt_q + CW'(1);
      end
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
      frame_inc     = h_wrap && v_wrap;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = RUN;
          hcnt_d        = '0;
          vcnt_d        = '0;
          line_start_d  = 1'b1;
          frame_start_d = 1'b1;
        end
      end
      RUN: begin
        if (stop) state_d = DRAIN;
      end
      DRAIN: begin
        if (start && !stop) begin
          state_d = RUN;
        end else if (advance && h_wrap && v_wrap) begin
          // Frame finished while draining: park without announcing a new frame.
          state_d       = IDLE;
          hcnt_d        = '0;
          vcnt_d        = '0;
          line_start_d  = 1'b0;
          frame_start_d = 1'b0;
          frame_inc     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode from next-state counters so registered outputs line up with registered hcnt/vcnt.
  always_comb begin
    hsync_d  = 1'b0;
    vsync_d  = 1'b0;
    csync_d  = 1'b0;
    cblank_d = 1'b1;
    active_d = 1'b0;
    if (state_d != IDLE) begin
      hsync_d  = in_window(hcnt_d, H_SYN_LO, H_SYN_HI);
      vsync_d  = in_window(vcnt_d, V_SYN_LO, V_SYN_HI);
      csync_d  = hsync_d | vsync_d;
      cblank_d = (hcnt_d >= H_VIS) | (vcnt_d >= V_VIS);
      active_d = !cblank_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      busy_q        <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      csync_q       <= 1'b0;
      cblank_q      <= 1'b1;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      busy_q        <= (state_d != IDLE);
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      csync_q       <= csync_d;
      cblank_q      <= cblank_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      if (frame_inc) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign busy        = busy_q;
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign csync       = csync_q;
  assign cblank      = cblank_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
